// File: rtl/mult8x8_seq_ctrl_if.sv
// Control bundle between the multiplier sequencer and its datapath/consumer.
// The master side issues start/done_ack, the slave side is the sequencer.
interface mult8x8_seq_ctrl_if;
    logic       start;
    logic       done_ack;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       acc_clr;
    logic       acc_en;
    logic [1:0] step;
    logic [1:0] state_out;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, done_ack,
        input  input_sel, shift_sel, acc_clr, acc_en,
        input  step, state_out, busy, done, err
    );

    modport slave (
        input  start, done_ack,
        output input_sel, shift_sel, acc_clr, acc_en,
        output step, state_out, busy, done, err
    );
endinterface

// File: rtl/mult8x8_seq_ctrl.sv
// Sequencer for an 8x8 multiply built from four 4x4 partial products.
// Walks LOAD -> CALC(4 steps) -> DONE under a start/done handshake.
module mult8x8_seq_ctrl #(
    parameter int AUTO_CLEAR = 0
) (
    input  logic                 clk,
    input  logic                 sclr,
    mult8x8_seq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CALC = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       err_q, err_d;

    logic [1:0] input_sel_q;
    logic [1:0] shift_sel_q;
    logic       acc_clr_q;
    logic       acc_en_q;
    logic       busy_q;
    logic       done_q;

    // Shift amount for a given step: lo*lo, cross terms, hi*hi.
    function automatic logic [1:0] shift_for(input logic [1:0] s);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b01;
            2'd2:    r = 2'b01;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    // Next-state, step and sticky-error logic.
    always_comb begin
        state_d = state_q;
        step_d  = 2'd0;
        err_d   = err_q;
        if (sclr) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                    end
                end
                LOAD: begin
                    state_d = CALC;
                    if (bus.start) err_d = 1'b1;
                end
                CALC: begin
                    if (bus.start) err_d = 1'b1;
                    if (step_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_d = LOAD;
                        err_d   = 1'b0;
                    end else if (AUTO_CLEAR != 0 || bus.done_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered datapath controls, decoded from the next state.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            err_q       <= 1'b0;
            input_sel_q <= 2'b00;
            shift_sel_q <= 2'b00;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            err_q       <= err_d;
            input_sel_q <= (state_d == CALC) ? step_d : 2'b00;
            shift_sel_q <= (state_d == CALC) ? shift_for(step_d) : 2'b00;
            acc_clr_q   <= (state_d == LOAD);
            acc_en_q    <= (state_d == CALC);
            busy_q      <= (state_d == LOAD) || (state_d == CALC);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.state_out = state_q;
    assign bus.step      = step_q;
    assign bus.err       = err_q;
    assign bus.input_sel = input_sel_q;
    assign bus.shift_sel = shift_sel_q;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_en    = acc_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl: a nibble datapath driven by the sequencer
// outputs, with products checked against plain a*b arithmetic.
module tb_mult8x8_seq_ctrl;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    mult8x8_seq_ctrl_if b0 ();
    mult8x8_seq_ctrl_if b1 ();

    mult8x8_seq_ctrl #(.AUTO_CLEAR(0)) u0 (.clk(clk), .sclr(sclr), .bus(b0));
    mult8x8_seq_ctrl #(.AUTO_CLEAR(1)) u1 (.clk(clk), .sclr(sclr), .bus(b1));

    int checks   = 0;
    int failures = 0;

    logic [7:0]  a0, bb0, a1, bb1;
    logic [15:0] acc0, acc1;
    logic [1:0]  exp_sh [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    // Datapath: 4x4 multiplier on selected nibbles, shifter, accumulator.
    function automatic logic [15:0] pp(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] isel, input logic [1:0] ssel);
        logic [3:0]  na, nb;
        logic [15:0] p;
        na = isel[1] ? a[7:4] : a[3:0];
        nb = isel[0] ? b[7:4] : b[3:0];
        p  = 16'(na) * 16'(nb);
        return p << (4 * ssel);
    endfunction

    always @(posedge clk) begin
        if (b0.acc_clr) acc0 <= 16'd0;
        else if (b0.acc_en) acc0 <= acc0 + pp(a0, bb0, b0.input_sel, b0.shift_sel);
        if (b1.acc_clr) acc1 <= 16'd0;
        else if (b1.acc_en) acc1 <= acc1 + pp(a1, bb1, b1.input_sel, b1.shift_sel);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        tick();
        tick();
        sclr = 1'b0;
        checks++;
        if ({b0.state_out, b0.step, b0.input_sel, b0.shift_sel, b0.acc_clr,
             b0.acc_en, b0.busy, b0.done, b0.err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_u0: state=%b step=%0d busy=%b done=%b err=%b expected all 0",
                     b0.state_out, b0.step, b0.busy, b0.done, b0.err);
        end
        checks++;
        if ({b1.state_out, b1.step, b1.input_sel, b1.shift_sel, b1.acc_clr,
             b1.acc_en, b1.busy, b1.done, b1.err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_u1: state=%b busy=%b done=%b expected all 0",
                     b1.state_out, b1.busy, b1.done);
        end
    endtask

    task automatic test_basic();
        a0 = 8'hA7;
        bb0 = 8'h3C;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        checks++;
        if (b0.state_out !== 2'b01 || b0.acc_clr !== 1'b1 || b0.busy !== 1'b1 ||
            b0.acc_en !== 1'b0) begin
            failures++;
            $display("FAIL basic_load: state=%b acc_clr=%b busy=%b acc_en=%b expected 01 1 1 0",
                     b0.state_out, b0.acc_clr, b0.busy, b0.acc_en);
        end
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            s = 2'(i);
            tick();
            checks++;
            if (b0.state_out !== 2'b10 || b0.step !== s || b0.input_sel !== s ||
                b0.shift_sel !== exp_sh[i] || b0.acc_en !== 1'b1 ||
                b0.busy !== 1'b1 || b0.acc_clr !== 1'b0) begin
                failures++;
                $display("FAIL basic_calc%0d: state=%b step=%0d isel=%b ssel=%b en=%b expected 10 %0d %b %b 1",
                         i, b0.state_out, b0.step, b0.input_sel, b0.shift_sel,
                         b0.acc_en, s, s, exp_sh[i]);
            end
        end
        tick();
        checks++;
        if (b0.done !== 1'b1 || b0.state_out !== 2'b11 || b0.busy !== 1'b0 ||
            b0.acc_en !== 1'b0 || b0.input_sel !== 2'b00) begin
            failures++;
            $display("FAIL basic_done: done=%b state=%b busy=%b expected 1 11 0",
                     b0.done, b0.state_out, b0.busy);
        end
        checks++;
        if (acc0 !== 16'h2724) begin
            failures++;
            $display("FAIL basic_product: got %h expected 2724", acc0);
        end
    endtask

    task automatic test_handshake();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (b0.done !== 1'b1 || b0.state_out !== 2'b11) begin
                failures++;
                $display("FAIL hold_done%0d: done=%b state=%b expected 1 11",
                         i, b0.done, b0.state_out);
            end
        end
        b0.done_ack = 1'b1;
        tick();
        b0.done_ack = 1'b0;
        checks++;
        if (b0.state_out !== 2'b00 || b0.done !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle: state=%b done=%b expected 00 0",
                     b0.state_out, b0.done);
        end
    endtask

    task automatic test_back_to_back();
        a0 = 8'($urandom);
        bb0 = 8'($urandom);
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        repeat (5) tick();
        checks++;
        if (b0.done !== 1'b1 || acc0 !== 16'(a0) * 16'(bb0)) begin
            failures++;
            $display("FAIL b2b_first: done=%b got %h expected %h",
                     b0.done, acc0, 16'(a0) * 16'(bb0));
        end
        a0 = 8'hFF;
        bb0 = 8'hFF;
        b0.start = 1'b1;
        b0.done_ack = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.done_ack = 1'b0;
        checks++;
        if (b0.state_out !== 2'b01) begin
            failures++;
            $display("FAIL b2b_load: state=%b expected 01", b0.state_out);
        end
        repeat (5) tick();
        checks++;
        if (b0.done !== 1'b1 || acc0 !== 16'hFE01) begin
            failures++;
            $display("FAIL b2b_second: done=%b got %h expected fe01", b0.done, acc0);
        end
        b0.done_ack = 1'b1;
        tick();
        b0.done_ack = 1'b0;
    endtask

    task automatic test_error();
        a0 = 8'($urandom);
        bb0 = 8'($urandom);
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick();
        tick();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        checks++;
        if (b0.err !== 1'b1 || b0.state_out !== 2'b10 || b0.step !== 2'd2) begin
            failures++;
            $display("FAIL err_set: err=%b state=%b step=%0d expected 1 10 2",
                     b0.err, b0.state_out, b0.step);
        end
        tick();
        tick();
        checks++;
        if (b0.done !== 1'b1 || b0.err !== 1'b1 || acc0 !== 16'(a0) * 16'(bb0)) begin
            failures++;
            $display("FAIL err_done: done=%b err=%b got %h expected 1 1 %h",
                     b0.done, b0.err, acc0, 16'(a0) * 16'(bb0));
        end
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        checks++;
        if (b0.state_out !== 2'b01 || b0.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: state=%b err=%b expected 01 0",
                     b0.state_out, b0.err);
        end
        repeat (5) tick();
        b0.done_ack = 1'b1;
        tick();
        b0.done_ack = 1'b0;
    endtask

    task automatic test_reset_midop();
        b0.start = 1'b1;
        tick();
        tick();
        b0.start = 1'b0;
        tick();
        tick();
        checks++;
        if (b0.err !== 1'b1 || b0.step !== 2'd2) begin
            failures++;
            $display("FAIL midop_pre: err=%b step=%0d expected 1 2", b0.err, b0.step);
        end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (b0.state_out !== 2'b00 || b0.step !== 2'd0 || b0.acc_en !== 1'b0 ||
            b0.busy !== 1'b0 || b0.err !== 1'b0 || b0.done !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: state=%b step=%0d en=%b busy=%b err=%b expected all 0",
                     b0.state_out, b0.step, b0.acc_en, b0.busy, b0.err);
        end
        sclr = 1'b1;
        b0.start = 1'b1;
        tick();
        sclr = 1'b0;
        b0.start = 1'b0;
        tick();
        checks++;
        if (b0.state_out !== 2'b00 || b0.busy !== 1'b0) begin
            failures++;
            $display("FAIL sclr_vs_start: state=%b busy=%b expected 00 0",
                     b0.state_out, b0.busy);
        end
        a0 = 8'($urandom);
        bb0 = 8'($urandom);
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        repeat (5) tick();
        checks++;
        if (b0.done !== 1'b1 || acc0 !== 16'(a0) * 16'(bb0)) begin
            failures++;
            $display("FAIL midop_fresh: done=%b got %h expected %h",
                     b0.done, acc0, 16'(a0) * 16'(bb0));
        end
        b0.done_ack = 1'b1;
        tick();
        b0.done_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic exp_err;
            int   dly;
            exp_err = 1'b0;
            a0 = 8'($urandom);
            bb0 = 8'($urandom);
            b0.start = 1'b1;
            tick();
            for (int c = 1; c <= 5; c++) begin
                b0.start = ($urandom_range(0, 3) == 0);
                if (b0.start) exp_err = 1'b1;
                b0.done_ack = $urandom_range(0, 1) == 1;
                tick();
            end
            b0.start = 1'b0;
            b0.done_ack = 1'b0;
            checks++;
            if (b0.state_out !== 2'b11 || b0.err !== exp_err ||
                acc0 !== 16'(a0) * 16'(bb0)) begin
                failures++;
                $display("FAIL rand%0d: state=%b err=%b prod=%h expected 11 %b %h",
                         n, b0.state_out, b0.err, acc0, exp_err, 16'(a0) * 16'(bb0));
            end
            dly = $urandom_range(0, 3);
            repeat (dly) tick();
            b0.done_ack = 1'b1;
            tick();
            b0.done_ack = 1'b0;
            checks++;
            if (b0.state_out !== 2'b00 || b0.done !== 1'b0) begin
                failures++;
                $display("FAIL rand_ack%0d: state=%b done=%b expected 00 0",
                         n, b0.state_out, b0.done);
            end
        end
    endtask

    task automatic test_start_held();
        a0 = 8'($urandom);
        bb0 = 8'($urandom);
        b0.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c % 6 == 0) begin
                checks++;
                if (b0.done !== 1'b1 || b0.err !== 1'b1 ||
                    acc0 !== 16'(a0) * 16'(bb0)) begin
                    failures++;
                    $display("FAIL held_done%0d: done=%b err=%b prod=%h expected 1 1 %h",
                             c, b0.done, b0.err, acc0, 16'(a0) * 16'(bb0));
                end
            end else begin
                checks++;
                if (b0.done !== 1'b0 || b0.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL held_busy%0d: done=%b busy=%b expected 0 1",
                             c, b0.done, b0.busy);
                end
            end
        end
        b0.start = 1'b0;
        b0.done_ack = 1'b1;
        tick();
        b0.done_ack = 1'b0;
        checks++;
        if (b0.state_out !== 2'b00) begin
            failures++;
            $display("FAIL held_exit: state=%b expected 00", b0.state_out);
        end
    endtask

    task automatic test_auto_clear();
        a1 = 8'($urandom);
        bb1 = 8'($urandom);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        repeat (5) tick();
        checks++;
        if (b1.done !== 1'b1 || acc1 !== 16'(a1) * 16'(bb1)) begin
            failures++;
            $display("FAIL ac_done: done=%b got %h expected 1 %h",
                     b1.done, acc1, 16'(a1) * 16'(bb1));
        end
        tick();
        checks++;
        if (b1.done !== 1'b0 || b1.state_out !== 2'b00) begin
            failures++;
            $display("FAIL ac_idle: done=%b state=%b expected 0 00",
                     b1.done, b1.state_out);
        end
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        repeat (5) tick();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        checks++;
        if (b1.state_out !== 2'b01) begin
            failures++;
            $display("FAIL ac_b2b: state=%b expected 01", b1.state_out);
        end
        repeat (6) tick();
        tick();
        checks++;
        if (b1.state_out !== 2'b00 || b1.done !== 1'b0) begin
            failures++;
            $display("FAIL ac_final: state=%b done=%b expected 00 0",
                     b1.state_out, b1.done);
        end
    endtask

    initial begin
        sclr = 1'b1;
        b0.start = 1'b0;
        b0.done_ack = 1'b0;
        b1.start = 1'b0;
        b1.done_ack = 1'b0;
        a0 = 8'd0;
        bb0 = 8'd0;
        a1 = 8'd0;
        bb1 = 8'd0;
        test_reset();
        test_basic();
        test_handshake();
        test_back_to_back();
        test_error();
        test_reset_midop();
        test_random();
        test_start_held();
        test_auto_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
